pc_sequencer: RTL and testbench

//  Control-side partner of the 8-bit program counter: reads the PC value, fetches the

---
 rtl/pc_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute controller for the 8-bit program counter.
// Reads the instruction addressed by the PC and drives the PC's load/increment
// inputs to run the timer micro-program (jumps, counted loops, waits, OUT, HALT).
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   run             execute when high; stop at the next instruction boundary when low
//   pc_in           current PC value (also the ROM address, not needed by the decode)
//   instr           ROM word at pc_in; opcode [15:12], operand [PC_W-1:0]
//   pc_load         1-cycle pulse, PC takes pc_load_val
//   pc_load_val     jump target, qualified by pc_load
//   pc_inc          1-cycle pulse, PC increments
//   out_port        value written by OUT
//   halted          high while in HALT
//   busy            high while in FETCH/EXEC/WAIT
module pc_sequencer #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_load_val,
  output logic               pc_inc,
  output logic [PC_W-1:0]    out_port,
  output logic               halted,
  output logic               busy
);

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_JMP  = 4'h1;
  localparam logic [OP_W-1:0] OP_LDC  = 4'h2;
  localparam logic [OP_W-1:0] OP_DJNZ = 4'h3;
  localparam logic [OP_W-1:0] OP_WAIT = 4'h4;
  localparam logic [OP_W-1:0] OP_OUT  = 4'h5;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WAIT  = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   loop_cnt, loop_cnt_nxt;
  logic [PC_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic              pc_load_nxt, pc_inc_nxt, halted_nxt, busy_nxt;
  logic [PC_W-1:0]   pc_load_val_nxt, out_port_nxt;
  logic [OP_W-1:0]   opcode;
  logic [PC_W-1:0]   operand;
  logic              unused_ok;

  assign opcode  = instr[INSTR_W-1 -: OP_W];
  assign operand = instr[PC_W-1:0];

  // pc_in and the middle instruction bits carry no meaning for the decode
  assign unused_ok = ^{pc_in, instr[INSTR_W-OP_W-1:PC_W]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (run) state_nxt = FETCH;
      FETCH: state_nxt = EXEC;
      EXEC: begin
        state_nxt = run ? FETCH : IDLE;
        if (opcode == OP_HALT)
          state_nxt = HALT;
        else if (opcode == OP_WAIT && operand != '0)
          state_nxt = WAIT;
      end
      // run is only honoured once the wait has expired
      WAIT:  if (wait_cnt == PC_W'(1)) state_nxt = run ? FETCH : IDLE;
      HALT:  state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values; pulses are registered so they appear
  // in the cycle after the deciding EXEC or final WAIT cycle
  always_comb begin
    pc_load_nxt     = 1'b0;
    pc_inc_nxt      = 1'b0;
    pc_load_val_nxt = pc_load_val;
    out_port_nxt    = out_port;
    loop_cnt_nxt    = loop_cnt;
    wait_cnt_nxt    = wait_cnt;
    case (state)
      EXEC: begin
        case (opcode)
          OP_JMP: begin
            pc_load_nxt     = 1'b1;
            pc_load_val_nxt = operand;
          end
          OP_LDC: begin
            loop_cnt_nxt = operand;
            pc_inc_nxt   = 1'b1;
          end
          OP_DJNZ: begin
            // a zero counter wraps to all-ones and therefore jumps
            loop_cnt_nxt = loop_cnt - PC_W'(1);
            if (loop_cnt_nxt != '0) begin
              pc_load_nxt     = 1'b1;
              pc_load_val_nxt = operand;
            end else begin
              pc_inc_nxt = 1'b1;
            end
          end
          OP_WAIT: begin
            if (operand == '0) pc_inc_nxt   = 1'b1;
            else               wait_cnt_nxt = operand;
          end
          OP_OUT: begin
            out_port_nxt = operand;
            pc_inc_nxt   = 1'b1;
          end
          OP_HALT: ;
          OP_NOP:  pc_inc_nxt = 1'b1;
          default: pc_inc_nxt = 1'b1;
        endcase
      end
      WAIT: begin
        wait_cnt_nxt = wait_cnt - PC_W'(1);
        if (wait_cnt == PC_W'(1)) pc_inc_nxt = 1'b1;
      end
      default: ;
    endcase
    halted_nxt = (state_nxt == HALT);
    busy_nxt   = (state_nxt == FETCH) || (state_nxt == EXEC) || (state_nxt == WAIT);
  end

  // Output and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_load     <= 1'b0;
      pc_inc      <= 1'b0;
      pc_load_val <= '0;
      out_port    <= '0;
      halted      <= 1'b0;
      busy        <= 1'b0;
      loop_cnt    <= '0;
      wait_cnt    <= '0;
    end else begin
      pc_load     <= pc_load_nxt;
      pc_inc      <= pc_inc_nxt;
      pc_load_val <= pc_load_val_nxt;
      out_port    <= out_port_nxt;
      halted      <= halted_nxt;
      busy        <= busy_nxt;
      loop_cnt    <= loop_cnt_nxt;
      wait_cnt    <= wait_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a behavioural PC and asynchronous program ROM close
// the loop; expected PC pulses (kind, target, cycle) are queued by the stimulus
// and a monitor pops and compares them whenever the DUT pulses.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic        pc_load, pc_inc, halted, busy;
  logic [7:0]  pc_load_val, out_port;

  logic [15:0] rom [0:255];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    bit         load;
    logic [7:0] val;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .pc_in       (pc),
    .instr       (instr),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .pc_inc      (pc_inc),
    .out_port    (out_port),
    .halted      (halted),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Program counter model and combinational ROM
  always @(posedge clk or posedge reset) begin
    if (reset)        pc <= 8'd0;
    else if (pc_load) pc <= pc_load_val;
    else if (pc_inc)  pc <= pc + 8'd1;
  end
  assign instr = rom[pc];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_inc(input int c);
    exp_t e;
    e.load = 1'b0; e.val = 8'd0; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_load(input int c, input logic [7:0] v);
    exp_t e;
    e.load = 1'b1; e.val = v; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; FETCH occupies the next cycle
  task automatic start_run(output int t0);
    t0  = cyc + 1;
    run = 1'b1;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  // Called at a negedge; asserts reset immediately
  task automatic do_reset();
    chk("missing_pulses", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    run   = 1'b0;
    #1;
    chk("reset_outputs", {pc_load, pc_inc, pc_load_val, out_port, halted, busy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every pulse must match the head of the expectation queue
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && (pc_inc || pc_load)) begin
        chk("single_pulse", 32'(pc_inc & pc_load), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got inc=%0b load=%0b expected none (cycle %0d)",
                   pc_inc, pc_load, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", 32'(pc_load), 32'(e.load));
          chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
          if (e.load) chk("load_val", 32'(pc_load_val), 32'(e.val));
        end
      end
    end
  end

  initial begin
    int t0, t1;
    reset = 1'b1;
    run   = 1'b0;
    fill_rom();
    #1;
    chk("reset_outputs", {pc_load, pc_inc, pc_load_val, out_port, halted, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: NOP, NOP, JMP 0 loops; reset lands mid-EXEC of a NOP
    fill_rom();
    rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h1000;
    @(negedge clk);
    start_run(t0);
    push_inc(t0 + 2);  push_inc(t0 + 4);  push_load(t0 + 6, 8'd0);
    push_inc(t0 + 8);  push_inc(t0 + 10); push_load(t0 + 12, 8'd0);
    wait_until(t0 + 13);
    chk("t1_busy", 32'(busy), 32'd1);
    do_reset();
    repeat (6) @(negedge clk);
    chk("t1_pc_after_reset", 32'(pc), 32'd0);
    chk("t1_idle_after_reset", 32'(busy), 32'd0);

    // 2: LDC 3 / OUT AA / DJNZ 1 / HALT
    fill_rom();
    rom[0] = 16'h2003; rom[1] = 16'h50AA; rom[2] = 16'h3001; rom[3] = 16'hF000;
    @(negedge clk);
    start_run(t0);
    push_inc(t0 + 2);
    push_inc(t0 + 4);  push_load(t0 + 6, 8'd1);
    push_inc(t0 + 8);  push_load(t0 + 10, 8'd1);
    push_inc(t0 + 12); push_inc(t0 + 14);
    wait_until(t0 + 20);
    chk("t2_out_port", 32'(out_port), 32'hAA);
    chk("t2_halted", 32'(halted), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_pc", 32'(pc), 32'd3);
    do_reset();

    // 3: WAIT 5 / NOP / WAIT 0 / HALT
    fill_rom();
    rom[0] = 16'h4005; rom[1] = 16'h0000; rom[2] = 16'h4000; rom[3] = 16'hF000;
    @(negedge clk);
    start_run(t0);
    push_inc(t0 + 7); push_inc(t0 + 9); push_inc(t0 + 11);
    wait_until(t0 + 4);
    chk("t3_busy_in_wait", 32'(busy), 32'd1);
    wait_until(t0 + 16);
    chk("t3_halted", 32'(halted), 32'd1);
    chk("t3_pc", 32'(pc), 32'd3);
    do_reset();

    // 4: LDC 0 then DJNZ 5 wraps the counter and jumps
    fill_rom();
    rom[0] = 16'h2000; rom[1] = 16'h3005; rom[5] = 16'hF000;
    @(negedge clk);
    start_run(t0);
    push_inc(t0 + 2); push_load(t0 + 4, 8'd5);
    wait_until(t0 + 10);
    chk("t4_pc", 32'(pc), 32'd5);
    chk("t4_halted", 32'(halted), 32'd1);
    do_reset();

    // 5: drop run during EXEC of NOP, resume later
    fill_rom();
    rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h5055; rom[3] = 16'hF000;
    @(negedge clk);
    start_run(t0);
    push_inc(t0 + 2);
    wait_until(t0 + 1);
    run = 1'b0;
    wait_until(t0 + 8);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_idle_halted", 32'(halted), 32'd0);
    chk("t5_pc_next", 32'(pc), 32'd1);
    start_run(t1);
    push_inc(t1 + 2); push_inc(t1 + 4);
    wait_until(t1 + 8);
    chk("t5_out_port", 32'(out_port), 32'h55);
    chk("t5_pc", 32'(pc), 32'd3);
    chk("t5_halted", 32'(halted), 32'd1);
    do_reset();

    // 6: reset in WAIT with wait_cnt=3; no pulse afterwards
    fill_rom();
    rom[0] = 16'h4005; rom[1] = 16'hF000;
    @(negedge clk);
    start_run(t0);
    wait_until(t0 + 4);
    chk("t6_busy_in_wait", 32'(busy), 32'd1);
    do_reset();
    repeat (10) @(negedge clk);
    chk("t6_pc", 32'(pc), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
